// File: rtl/omsp_hmac_defs.sv
// Shared definitions for the HMAC sequencer and its wrapper-side models.
package omsp_hmac_defs;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HRST      = 4'd1;
  localparam logic [3:0] S_INIT      = 4'd2;
  localparam logic [3:0] S_INIT_WAIT = 4'd3;
  localparam logic [3:0] S_RD        = 4'd4;
  localparam logic [3:0] S_FEED      = 4'd5;
  localparam logic [3:0] S_FEED_WAIT = 4'd6;
  localparam logic [3:0] S_OUT       = 4'd7;
  localparam logic [3:0] S_OUT_WAIT  = 4'd8;
  localparam logic [3:0] S_WR        = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  function automatic int unsigned tag_words(input int unsigned key_size);
    return key_size / 16;
  endfunction

  // Memory is little-endian; the wrapper wants the lower-address byte first.
  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/omsp_mac_seq.sv
// Sequencer that restarts the HMAC wrapper, streams a memory range into it,
// then reads the tag back out and writes it to memory.
module omsp_mac_seq
  import omsp_hmac_defs::*;
#(
  parameter int unsigned KEY_SIZE = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [15:0] cmd_data_addr,
  input  logic [15:0] cmd_data_len,
  input  logic [15:0] cmd_tag_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        hmac_reset,
  output logic        hmac_start_continue,
  output logic        hmac_data_available,
  output logic        hmac_data_is_long,
  output logic [15:0] hmac_data_in,
  input  logic [15:0] hmac_data_out,
  input  logic        hmac_busy
);

  localparam int unsigned TAG_WORDS = tag_words(KEY_SIZE);
  localparam logic [15:0] LAST_TAG  = 16'(TAG_WORDS - 1);

  logic [3:0]  state;
  logic [15:0] rd_addr;
  logic [15:0] wr_addr;
  logic [15:0] remaining;
  logic [15:0] tag_cnt;
  logic        error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      rd_addr           <= '0;
      wr_addr           <= '0;
      remaining         <= '0;
      tag_cnt           <= '0;
      error_q           <= 1'b0;
      mem_wdata         <= '0;
      hmac_data_in      <= '0;
      hmac_data_is_long <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            if (cmd_data_addr[0] || cmd_tag_addr[0]) begin
              error_q <= 1'b1;
            end else begin
              state     <= S_HRST;
              rd_addr   <= cmd_data_addr;
              wr_addr   <= cmd_tag_addr;
              remaining <= cmd_data_len;
              tag_cnt   <= '0;
            end
          end
        end
        S_HRST: state <= S_INIT;
        S_INIT: state <= S_INIT_WAIT;
        S_INIT_WAIT, S_FEED_WAIT: begin
          if (!hmac_busy) begin
            state <= (remaining != '0) ? S_RD : S_OUT;
          end
        end
        S_RD: begin
          if (mem_ack) begin
            rd_addr <= rd_addr + 16'd2;
            state   <= S_FEED;
            if (remaining > 16'd1) begin
              hmac_data_in      <= byte_swap(mem_rdata);
              hmac_data_is_long <= 1'b1;
              remaining         <= remaining - 16'd2;
            end else begin
              // Odd trailing byte: only the lower-address byte is valid.
              hmac_data_in      <= {8'h00, mem_rdata[7:0]};
              hmac_data_is_long <= 1'b0;
              remaining         <= '0;
            end
          end
        end
        S_FEED: state <= S_FEED_WAIT;
        S_OUT:  state <= S_OUT_WAIT;
        S_OUT_WAIT: begin
          if (!hmac_busy) begin
            mem_wdata <= hmac_data_out;
            state     <= S_WR;
          end
        end
        S_WR: begin
          if (mem_ack) begin
            wr_addr <= wr_addr + 16'd2;
            if (tag_cnt == LAST_TAG) begin
              state <= S_DONE;
            end else begin
              tag_cnt <= tag_cnt + 16'd1;
              state   <= S_OUT;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy                = (state != S_IDLE);
  assign done                = (state == S_DONE);
  assign error               = error_q;
  assign mem_req             = (state == S_RD) || (state == S_WR);
  assign mem_we              = (state == S_WR);
  assign mem_addr            = (state == S_RD) ? rd_addr :
                               (state == S_WR) ? wr_addr : '0;
  assign hmac_reset          = reset || (state == S_HRST);
  assign hmac_start_continue = (state == S_INIT) || (state == S_FEED) || (state == S_OUT);
  assign hmac_data_available = (state == S_INIT) || (state == S_FEED);

endmodule

// File: tb/tb_omsp_mac_seq.sv
// Directed and randomized bench for omsp_mac_seq with memory and wrapper models.
module tb_omsp_mac_seq;

  logic        clk;
  logic        reset;
  logic        cmd_start;
  logic [15:0] cmd_data_addr;
  logic [15:0] cmd_data_len;
  logic [15:0] cmd_tag_addr;
  logic        busy, done, error;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        hmac_reset, hmac_start_continue, hmac_data_available, hmac_data_is_long;
  logic [15:0] hmac_data_in, hmac_data_out;
  logic        hmac_busy;

  logic [15:0] mem [0:32767];
  logic [16:0] exp_feed_q[$];
  logic [31:0] exp_wr_q[$];

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int unsigned ack_delay_max = 0;
  int unsigned hmac_stretch_max = 0;

  omsp_mac_seq #(.KEY_SIZE(128)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start),
    .cmd_data_addr(cmd_data_addr), .cmd_data_len(cmd_data_len), .cmd_tag_addr(cmd_tag_addr),
    .busy(busy), .done(done), .error(error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hmac_reset(hmac_reset), .hmac_start_continue(hmac_start_continue),
    .hmac_data_available(hmac_data_available), .hmac_data_is_long(hmac_data_is_long),
    .hmac_data_in(hmac_data_in), .hmac_data_out(hmac_data_out), .hmac_busy(hmac_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] acc_step(input logic [15:0] acc, input logic [15:0] d, input logic is_long);
    logic [15:0] v;
    v = is_long ? d : {8'h00, d[7:0]};
    return {acc[14:0], acc[15]} ^ v ^ (is_long ? 16'h0000 : 16'h5A5A);
  endfunction

  function automatic logic [15:0] tag_word(input logic [15:0] acc, input int unsigned k);
    logic [15:0] m;
    m = 16'(16'h1357 * (k + 1));
    return acc ^ m;
  endfunction

  // Memory responder: random ack latency, bus-hold and write scoreboard checks.
  initial begin : mem_model
    logic in_req, last_ack, q_we;
    logic [15:0] q_addr, q_wdata;
    logic [31:0] e;
    int unsigned dly;
    in_req = 1'b0; last_ack = 1'b0; q_we = 1'b0; q_addr = '0; q_wdata = '0; dly = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset) begin
        in_req = 1'b0; last_ack = 1'b0;
      end else begin
        if (last_ack) check("req_drop_after_ack", mem_req, 1'b0);
        last_ack = 1'b0;
        if (mem_req) begin
          if (!in_req) begin
            in_req = 1'b1;
            dly = $urandom_range(ack_delay_max, 0);
            q_addr = mem_addr; q_we = mem_we; q_wdata = mem_wdata;
          end else begin
            check("bus_addr_hold", mem_addr, q_addr);
            check("bus_we_hold", mem_we, q_we);
            check("bus_wdata_hold", mem_wdata, q_wdata);
          end
          if (dly == 0) begin
            mem_ack = 1'b1; in_req = 1'b0; last_ack = 1'b1;
            if (mem_we) begin
              wr_cnt++;
              check("wr_expected", exp_wr_q.size() != 0, 1'b1);
              if (exp_wr_q.size() != 0) begin
                e = exp_wr_q.pop_front();
                check("wr_addr", mem_addr, e[31:16]);
                check("wr_data", mem_wdata, e[15:0]);
              end
              mem[mem_addr[15:1]] = mem_wdata;
            end else begin
              rd_cnt++;
              mem_rdata = mem[mem_addr[15:1]];
            end
          end else begin
            dly--;
          end
        end else begin
          in_req = 1'b0;
        end
      end
    end
  end

  // Wrapper model: busy stretches, feed scoreboard, tag generation.
  initial begin : hmac_model
    logic init_done, prev_sc, held_l;
    logic [15:0] acc, held_d;
    logic [16:0] e;
    int unsigned busy_cnt, hold_cnt, out_idx;
    init_done = 1'b0; prev_sc = 1'b0; held_l = 1'b0; acc = '0; held_d = '0;
    busy_cnt = 0; hold_cnt = 0; out_idx = 0;
    hmac_busy = 1'b0; hmac_data_out = '0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) busy_cnt--;
      if (hmac_reset) begin
        init_done = 1'b0; busy_cnt = 0; hold_cnt = 0; prev_sc = 1'b0;
      end else begin
        if (hold_cnt > 0) begin
          check("feed_hold_data", hmac_data_in, held_d);
          check("feed_hold_long", hmac_data_is_long, held_l);
          hold_cnt--;
        end
        if (hmac_start_continue) begin
          check("strobe_one_cycle", prev_sc, 1'b0);
          busy_cnt = $urandom_range(hmac_stretch_max, 0);
          if (hmac_data_available && !init_done) begin
            init_done = 1'b1; acc = 16'hACE1; out_idx = 0;
          end else if (hmac_data_available) begin
            check("feed_expected", exp_feed_q.size() != 0, 1'b1);
            if (exp_feed_q.size() != 0) begin
              e = exp_feed_q.pop_front();
              check("feed_is_long", hmac_data_is_long, e[16]);
              if (e[16]) check("feed_word", hmac_data_in, e[15:0]);
              else       check("feed_odd_byte", hmac_data_in[7:0], e[7:0]);
            end
            acc = acc_step(acc, hmac_data_in, hmac_data_is_long);
            held_d = hmac_data_in; held_l = hmac_data_is_long; hold_cnt = busy_cnt;
          end else begin
            check("out_after_init", init_done, 1'b1);
            hmac_data_out = tag_word(acc, out_idx);
            out_idx++;
          end
        end
        prev_sc = hmac_start_continue;
      end
      hmac_busy = (busy_cnt > 0);
    end
  end

  task automatic build_expect(input logic [15:0] da, input logic [15:0] len, input logic [15:0] ta);
    logic [15:0] rem, addr, w, f, acc;
    acc = 16'hACE1; rem = len; addr = da;
    while (rem != 0) begin
      w = mem[addr[15:1]];
      if (rem >= 2) begin
        f = {w[7:0], w[15:8]};
        exp_feed_q.push_back({1'b1, f});
        acc = acc_step(acc, f, 1'b1);
        rem = rem - 16'd2;
      end else begin
        f = {8'h00, w[7:0]};
        exp_feed_q.push_back({1'b0, f});
        acc = acc_step(acc, f, 1'b0);
        rem = '0;
      end
      addr = addr + 16'd2;
    end
    for (int unsigned k = 0; k < 8; k++) begin
      exp_wr_q.push_back({16'(ta + 16'(2 * k)), tag_word(acc, k)});
    end
  endtask

  task automatic start_cmd(input logic [15:0] da, input logic [15:0] len, input logic [15:0] ta);
    @(negedge clk);
    cmd_data_addr = da; cmd_data_len = len; cmd_tag_addr = ta; cmd_start = 1'b1;
    @(negedge clk);
    check("busy_after_accept", busy, 1'b1);
    check("hmac_reset_in_hrst", hmac_reset, 1'b1);
    // A second strobe while busy (odd address, new fields) must be ignored.
    cmd_data_addr = 16'h0001; cmd_data_len = 16'hFFFF; cmd_tag_addr = 16'(($urandom));
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic run_cmd(input logic [15:0] da, input logic [15:0] len, input logic [15:0] ta);
    int unsigned cyc;
    int err_seen;
    rd_cnt = 0; wr_cnt = 0; err_seen = 0; cyc = 0;
    build_expect(da, len, ta);
    start_cmd(da, len, ta);
    while (!done && cyc < 4000) begin
      if (error) err_seen++;
      @(negedge clk);
      cyc++;
    end
    check("done_pulse", done, 1'b1);
    check("busy_with_done", busy, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    check("no_error_while_busy", err_seen, 0);
    check("read_count", rd_cnt, (int'(len) + 1) / 2);
    check("write_count", wr_cnt, 8);
    check("feeds_consumed", exp_feed_q.size(), 0);
    check("writes_consumed", exp_wr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 16'h0000);
    check({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
    check({tag, "_data_in"}, hmac_data_in, 16'h0000);
    check({tag, "_sc"}, hmac_start_continue, 1'b0);
    check({tag, "_avail"}, hmac_data_available, 1'b0);
    check({tag, "_long"}, hmac_data_is_long, 1'b0);
    check({tag, "_hmac_reset"}, hmac_reset, 1'b1);
  endtask

  task automatic reset_during(input logic want_we);
    int unsigned cyc;
    cyc = 0;
    ack_delay_max = 5; hmac_stretch_max = 3;
    build_expect(16'h0200, 16'd6, 16'h0300);
    start_cmd(16'h0200, 16'd6, 16'h0300);
    while (!(mem_req && mem_we == want_we) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("reset_target_reached", mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs(want_we ? "rst_wr" : "rst_rd");
    reset = 1'b0;
    exp_feed_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_after_reset", done, 1'b0);
    end
    run_cmd(16'h0210, 16'd5, 16'h0320);
  endtask

  initial begin : stimulus
    reset = 1'b1; cmd_start = 1'b0;
    cmd_data_addr = '0; cmd_data_len = '0; cmd_tag_addr = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'hC3A5;
    mem[16'h0100] = 16'h1122;
    mem[16'h0101] = 16'h3344;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // Length 4: feeds 0x2211, 0x4433; eight tag writes at 0x0300..0x030E.
    run_cmd(16'h0200, 16'd4, 16'h0300);
    // Length 3: second feed is the odd byte 0x44.
    run_cmd(16'h0200, 16'd3, 16'h0300);
    // Length 0: no reads at all.
    run_cmd(16'h0400, 16'd0, 16'h0500);

    // Odd data address is rejected without any activity.
    @(negedge clk);
    cmd_data_addr = 16'h0201; cmd_data_len = 16'd4; cmd_tag_addr = 16'h0300; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("odd_error_pulse", error, 1'b1);
    check("odd_busy", busy, 1'b0);
    @(negedge clk);
    check("odd_error_one_cycle", error, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("odd_no_req", mem_req, 1'b0);
      check("odd_no_strobe", hmac_start_continue, 1'b0);
      check("odd_no_hmac_reset", hmac_reset, 1'b0);
      check("odd_no_busy", busy, 1'b0);
      @(negedge clk);
    end

    // Randomized latencies, lengths and addresses, including an address wrap.
    ack_delay_max = 5; hmac_stretch_max = 4;
    run_cmd(16'hFFFC, 16'd8, 16'h0600);
    for (int n = 0; n < 6; n++) begin
      logic [15:0] da, ta, len;
      da  = 16'($urandom_range(16'h7FFF, 0)) & 16'hFFFE;
      ta  = 16'($urandom_range(16'hFFFF, 16'h8000)) & 16'hFFFE;
      len = 16'($urandom_range(21, 0));
      run_cmd(da, len, ta);
    end

    reset_during(1'b0);
    reset_during(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", checks, failures);
    $finish;
  end

endmodule
